cache_controller: RTL and testbench

- Sequencing FSM for the 8-line direct-mapped write-back ACE cache datapath.
- Accepts CPU load/store requests and reads hit/miss/line-state status from the datapath.
- Drives the datapath write strobes, state-select and ACE transaction-type selects; owns all ACE VALID/READY handshakes (AR, R, AW, W, B, AC, CR, CD).
- Arbitrates between CPU requests and interconnect snoops for the single datapath.

---
 rtl/cache_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cache_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - sequencing FSM for the 8-line direct-mapped write-back ACE cache (optional watchdog: CTRL_TIMEOUT_EN)
module cache_controller #(
    parameter int WIDTH_STATE    = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    output logic                   cpu_done,
    output logic                   cpu_err,
    input  logic                   cache_hit,
    input  logic                   cache_miss,
    input  logic [WIDTH_STATE-1:0] line_state,
    input  logic                   snoop_miss,
    input  logic                   invalid,
    input  logic                   B_okay,
    input  logic                   R_okay,
    input  logic [4:0]             cr_resp_in,
    output logic                   write_from_cpu,
    output logic                   write_from_interconnect,
    output logic                   mux_en,
    output logic                   read_resp_en,
    output logic                   ac_enable,
    output logic [WIDTH_STATE-1:0] new_state,
    output logic                   read_shared,
    output logic                   make_unique,
    output logic                   write_clean,
    output logic                   AR_VALID,
    input  logic                   AR_READY,
    input  logic                   R_VALID,
    input  logic                   R_LAST,
    output logic                   R_READY,
    output logic                   AW_VALID,
    input  logic                   AW_READY,
    output logic                   W_VALID,
    input  logic                   W_READY,
    input  logic                   B_VALID,
    output logic                   B_READY,
    input  logic                   AC_VALID,
    output logic                   AC_READY,
    output logic                   CR_VALID,
    input  logic                   CR_READY,
    output logic                   CD_VALID,
    input  logic                   CD_READY,
    output logic [4:0]             CR_RESP
);

    localparam logic [WIDTH_STATE-1:0] ST_UC = WIDTH_STATE'(0);
    localparam logic [WIDTH_STATE-1:0] ST_UD = WIDTH_STATE'(1);
    localparam logic [WIDTH_STATE-1:0] ST_SD = WIDTH_STATE'(3);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_ADDR,
        S_WB_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_MERGE,
        S_SNOOP_EVAL,
        S_SNOOP_RESP
    } state_t;

    state_t state, next_state;

    // Per-transaction context latched in LOOKUP so the ACE select stays stable
    logic is_store;
    logic is_upgrade;
    // Handshake-complete flags for channels that may be accepted in different cycles
    logic aw_done, w_done, cr_done, cd_done;
    logic wait_state;
    logic timeout;

    assign wait_state = (state == S_WB_ADDR) || (state == S_WB_RESP) ||
                        (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                        (state == S_SNOOP_RESP);

`ifdef CTRL_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Watchdog: restarts on every state change, counts only while waiting on the interconnect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (next_state != state) begin
            wd_cnt <= '0;
        end else if (wait_state) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign timeout = wait_state && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: the condition is constant false and waits are unbounded
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Transaction context, handshake bookkeeping and the registered snoop response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store   <= 1'b0;
            is_upgrade <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            cr_done    <= 1'b0;
            cd_done    <= 1'b0;
            CR_RESP    <= '0;
        end else begin
            if (state == S_LOOKUP) begin
                is_store   <= cpu_we;
                is_upgrade <= cache_hit;
            end
            aw_done <= (state == S_WB_ADDR) && (next_state == S_WB_ADDR) && (aw_done || (AW_VALID && AW_READY));
            w_done  <= (state == S_WB_ADDR) && (next_state == S_WB_ADDR) && (w_done || (W_VALID && W_READY));
            cr_done <= (state == S_SNOOP_RESP) && (next_state == S_SNOOP_RESP) && (cr_done || (CR_VALID && CR_READY));
            cd_done <= (state == S_SNOOP_RESP) && (next_state == S_SNOOP_RESP) && (cd_done || (CD_VALID && CD_READY));
            // A snoop that missed or hit an invalid line can neither pass data nor claim the line
            if (state == S_SNOOP_EVAL) begin
                CR_RESP <= (snoop_miss || invalid) ? 5'd0 : cr_resp_in;
            end
        end
    end

    // Next-state decode and all handshake / datapath control outputs
    always_comb begin
        next_state              = state;
        cpu_done                = 1'b0;
        cpu_err                 = 1'b0;
        write_from_cpu          = 1'b0;
        write_from_interconnect = 1'b0;
        mux_en                  = 1'b0;
        read_resp_en            = 1'b0;
        ac_enable               = 1'b0;
        new_state               = '0;
        read_shared             = 1'b0;
        make_unique             = 1'b0;
        write_clean             = 1'b0;
        AR_VALID                = 1'b0;
        R_READY                 = 1'b0;
        AW_VALID                = 1'b0;
        W_VALID                 = 1'b0;
        B_READY                 = 1'b0;
        AC_READY                = 1'b0;
        CR_VALID                = 1'b0;
        CD_VALID                = 1'b0;

        case (state)
            S_IDLE: begin
                if (AC_VALID) begin
                    AC_READY   = 1'b1;
                    next_state = S_SNOOP_EVAL;
                end else if (cpu_req) begin
                    next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cache_hit) begin
                    if (!cpu_we) begin
                        cpu_done   = 1'b1;
                        next_state = S_IDLE;
                    end else if (line_state == ST_UC || line_state == ST_UD) begin
                        write_from_cpu = 1'b1;
                        mux_en         = 1'b1;
                        new_state      = ST_UD;
                        cpu_done       = 1'b1;
                        next_state     = S_IDLE;
                    end else begin
                        next_state = S_RD_ADDR;
                    end
                end else if (cache_miss) begin
                    if (line_state == ST_UD || line_state == ST_SD) begin
                        next_state = S_WB_ADDR;
                    end else begin
                        next_state = S_RD_ADDR;
                    end
                end else begin
                    // Datapath reported neither hit nor miss: refuse the access
                    cpu_err    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_WB_ADDR: begin
                write_clean = 1'b1;
                AW_VALID    = !aw_done;
                W_VALID     = !w_done;
                if ((aw_done || AW_READY) && (w_done || W_READY)) begin
                    next_state = S_WB_RESP;
                end
            end
            S_WB_RESP: begin
                B_READY = 1'b1;
                if (B_VALID) begin
                    if (B_okay) begin
                        next_state = S_RD_ADDR;
                    end else begin
                        cpu_err    = 1'b1;
                        next_state = S_IDLE;
                    end
                end
            end
            S_RD_ADDR: begin
                AR_VALID    = 1'b1;
                read_shared = !is_store;
                make_unique = is_store;
                if (AR_READY) begin
                    next_state = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                R_READY     = 1'b1;
                read_shared = !is_store;
                make_unique = is_store;
                if (R_VALID) begin
                    if (!R_LAST || !R_okay) begin
                        cpu_err    = 1'b1;
                        next_state = S_IDLE;
                    end else if (!is_store) begin
                        write_from_interconnect = 1'b1;
                        read_resp_en            = 1'b1;
                        cpu_done                = 1'b1;
                        next_state              = S_IDLE;
                    end else if (!is_upgrade) begin
                        write_from_interconnect = 1'b1;
                        mux_en                  = 1'b1;
                        new_state               = ST_UD;
                        next_state              = S_MERGE;
                    end else begin
                        next_state = S_MERGE;
                    end
                end
            end
            S_MERGE: begin
                write_from_cpu = 1'b1;
                mux_en         = 1'b1;
                new_state      = ST_UD;
                cpu_done       = 1'b1;
                next_state     = S_IDLE;
            end
            S_SNOOP_EVAL: begin
                ac_enable  = 1'b1;
                next_state = S_SNOOP_RESP;
            end
            S_SNOOP_RESP: begin
                CR_VALID = !cr_done;
                CD_VALID = CR_RESP[0] && !cd_done;
                if ((cr_done || CR_READY) && (!CR_RESP[0] || cd_done || CD_READY)) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Watchdog expiry: abandon the wait; only CPU-side waits report an error
        if (timeout) begin
            AR_VALID                = 1'b0;
            AW_VALID                = 1'b0;
            W_VALID                 = 1'b0;
            CR_VALID                = 1'b0;
            CD_VALID                = 1'b0;
            R_READY                 = 1'b0;
            B_READY                 = 1'b0;
            write_from_interconnect = 1'b0;
            read_resp_en            = 1'b0;
            mux_en                  = 1'b0;
            new_state               = '0;
            cpu_done                = 1'b0;
            cpu_err                 = (state != S_SNOOP_RESP);
            next_state              = S_IDLE;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized self-checking bench for cache_controller
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       cpu_req, cpu_we, cache_hit, cache_miss, snoop_miss, invalid, B_okay, R_okay;
    logic [2:0] line_state;
    logic [4:0] cr_resp_in;
    logic       AR_READY, R_VALID, R_LAST, AW_READY, W_READY, B_VALID, AC_VALID, CR_READY, CD_READY;
    logic       cpu_done, cpu_err, write_from_cpu, write_from_interconnect, mux_en, read_resp_en, ac_enable;
    logic [2:0] new_state;
    logic       read_shared, make_unique, write_clean;
    logic       AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, AC_READY, CR_VALID, CD_VALID;
    logic [4:0] CR_RESP;

    cache_controller dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .cache_hit(cache_hit), .cache_miss(cache_miss), .line_state(line_state), .snoop_miss(snoop_miss),
        .invalid(invalid), .B_okay(B_okay), .R_okay(R_okay), .cr_resp_in(cr_resp_in),
        .write_from_cpu(write_from_cpu), .write_from_interconnect(write_from_interconnect), .mux_en(mux_en),
        .read_resp_en(read_resp_en), .ac_enable(ac_enable), .new_state(new_state), .read_shared(read_shared),
        .make_unique(make_unique), .write_clean(write_clean), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_LAST(R_LAST), .R_READY(R_READY), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_READY(W_READY), .B_VALID(B_VALID), .B_READY(B_READY), .AC_VALID(AC_VALID),
        .AC_READY(AC_READY), .CR_VALID(CR_VALID), .CR_READY(CR_READY), .CD_VALID(CD_VALID), .CD_READY(CD_READY),
        .CR_RESP(CR_RESP)
    );

    localparam int B_DONE = 25, B_ERR = 24, B_WFC = 23, B_WFI = 22, B_MUX = 21, B_RRE = 20, B_ACE = 19;
    localparam int B_NS0 = 16, B_RS = 15, B_MU = 14, B_WC = 13, B_AR = 12, B_RR = 11, B_AW = 10, B_W = 9;
    localparam int B_BR = 8, B_ACR = 7, B_CRV = 6, B_CDV = 5;
    localparam logic [25:0] MASK_NO_CR = 26'h3FF_FFE0;
    localparam logic [25:0] MASK_ALL   = 26'h3FF_FFFF;

    logic [25:0] act_v, exp_v, pin_mask, pin_val;
    logic [4:0]  exp_cr;
    bit          chk_en = 1'b0;
    bit          pin_en = 1'b0;
    string       pin_name = "";
    int          vectors = 0;
    int          miscompares = 0;

    assign act_v = {cpu_done, cpu_err, write_from_cpu, write_from_interconnect, mux_en, read_resp_en, ac_enable,
                    new_state, read_shared, make_unique, write_clean, AR_VALID, R_READY, AW_VALID, W_VALID,
                    B_READY, AC_READY, CR_VALID, CD_VALID, CR_RESP};

    // Compare every cycle's outputs against the model, plus literal pins on chosen cycles
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
        if (pin_en) begin
            vectors++;
            if ((act_v & pin_mask) !== pin_val) begin
                miscompares++;
                $display("FAIL pin_%s t=%0t actual=%h required=%h", pin_name, $time, act_v & pin_mask, pin_val);
            end
        end
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic exp_clear();
        exp_v = {21'd0, exp_cr};
    endtask

    task automatic fin_cycle(input bit up, input logic [25:0] pm, input logic [25:0] pv, input string pn);
        if (up) begin
            pin_en   = 1'b1;
            pin_mask = pm;
            pin_val  = pv;
            pin_name = pn;
        end
        tick();
    endtask

    task automatic in_idle();
        cpu_req = 0; cpu_we = 0; cache_hit = 0; cache_miss = 0; line_state = 0; snoop_miss = 0; invalid = 0;
        B_okay = 0; R_okay = 0; cr_resp_in = 0; AR_READY = 0; R_VALID = 0; R_LAST = 0; AW_READY = 0;
        W_READY = 0; B_VALID = 0; AC_VALID = 0; CR_READY = 0; CD_READY = 0;
    endtask

    task automatic drive_cpu(input bit we);
        in_idle();
        cpu_req = 1'b1;
        cpu_we  = we;
    endtask

    // One CPU access, expressed as its sequence of phases: lookup, optional write-back, optional read, optional merge
    task automatic cpu_txn(input bit we, input bit hit, input logic [2:0] ls,
                           input int aw_d, input int w_d, input int b_d, input bit b_ok,
                           input int ar_d, input int r_d, input bit r_ok, input bit r_last,
                           input bit up, input logic [25:0] pm, input logic [25:0] pv, input string pn);
        bit upgrade, dirty;
        drive_cpu(we);
        exp_clear();
        tick();
        drive_cpu(we);
        cache_hit = hit; cache_miss = !hit; line_state = ls;
        exp_clear();
        if (hit && !we) begin
            exp_v[B_DONE] = 1'b1;
            fin_cycle(up, pm, pv, pn);
            return;
        end
        if (hit && we && (ls == 3'd0 || ls == 3'd1)) begin
            exp_v[B_WFC] = 1'b1; exp_v[B_MUX] = 1'b1; exp_v[B_NS0] = 1'b1; exp_v[B_DONE] = 1'b1;
            fin_cycle(up, pm, pv, pn);
            return;
        end
        upgrade = hit;
        dirty   = !hit && (ls == 3'd1 || ls == 3'd3);
        tick();
        if (dirty) begin
            for (int c = 0; c <= imax(aw_d, w_d); c++) begin
                drive_cpu(we);
                AW_READY = (c == aw_d) ? 1'b1 : ((c > aw_d) ? rbit() : 1'b0);
                W_READY  = (c == w_d) ? 1'b1 : ((c > w_d) ? rbit() : 1'b0);
                exp_clear();
                exp_v[B_WC] = 1'b1;
                exp_v[B_AW] = (c <= aw_d);
                exp_v[B_W]  = (c <= w_d);
                tick();
            end
            for (int c = 0; c <= b_d; c++) begin
                drive_cpu(we);
                B_VALID = (c == b_d);
                B_okay  = (c == b_d) ? b_ok : rbit();
                exp_clear();
                exp_v[B_BR] = 1'b1;
                if (c == b_d && !b_ok) begin
                    exp_v[B_ERR] = 1'b1;
                    fin_cycle(up, pm, pv, pn);
                    return;
                end
                tick();
            end
        end
        for (int c = 0; c <= ar_d; c++) begin
            drive_cpu(we);
            AR_READY = (c == ar_d);
            exp_clear();
            exp_v[B_AR] = 1'b1; exp_v[B_RS] = !we; exp_v[B_MU] = we;
            tick();
        end
        for (int c = 0; c <= r_d; c++) begin
            drive_cpu(we);
            R_VALID = (c == r_d);
            R_LAST  = (c == r_d) ? r_last : rbit();
            R_okay  = (c == r_d) ? r_ok : rbit();
            exp_clear();
            exp_v[B_RR] = 1'b1; exp_v[B_RS] = !we; exp_v[B_MU] = we;
            if (c == r_d) begin
                if (!r_last || !r_ok) begin
                    exp_v[B_ERR] = 1'b1;
                    fin_cycle(up, pm, pv, pn);
                    return;
                end
                if (!we) begin
                    exp_v[B_WFI] = 1'b1; exp_v[B_RRE] = 1'b1; exp_v[B_DONE] = 1'b1;
                    fin_cycle(up, pm, pv, pn);
                    return;
                end
                if (!upgrade) begin
                    exp_v[B_WFI] = 1'b1; exp_v[B_MUX] = 1'b1; exp_v[B_NS0] = 1'b1;
                end
            end
            tick();
        end
        drive_cpu(we);
        exp_clear();
        exp_v[B_WFC] = 1'b1; exp_v[B_MUX] = 1'b1; exp_v[B_NS0] = 1'b1; exp_v[B_DONE] = 1'b1;
        fin_cycle(up, pm, pv, pn);
    endtask

    // One snoop: accept in IDLE, evaluate, then respond on CR (and CD when data is passed)
    task automatic snoop_txn(input logic [4:0] resp, input bit miss, input bit inv, input int cr_d, input int cd_d,
                             input bit cpu_pend, input bit we, input bit up, input logic [25:0] pv, input string pn);
        bit has_cd;
        in_idle();
        AC_VALID = 1'b1; cpu_req = cpu_pend; cpu_we = we;
        exp_clear();
        exp_v[B_ACR] = 1'b1;
        tick();
        in_idle();
        cpu_req = cpu_pend; cpu_we = we;
        cr_resp_in = resp; snoop_miss = miss; invalid = inv;
        exp_clear();
        exp_v[B_ACE] = 1'b1;
        tick();
        exp_cr = (miss || inv) ? 5'd0 : resp;
        has_cd = exp_cr[0];
        for (int c = 0; c <= (has_cd ? imax(cr_d, cd_d) : cr_d); c++) begin
            in_idle();
            cpu_req = cpu_pend; cpu_we = we;
            CR_READY = (c == cr_d) ? 1'b1 : ((c > cr_d) ? rbit() : 1'b0);
            CD_READY = (c == cd_d) ? 1'b1 : ((c > cd_d || !has_cd) ? rbit() : 1'b0);
            exp_clear();
            exp_v[B_CRV] = (c <= cr_d);
            exp_v[B_CDV] = has_cd && (c <= cd_d);
            if (c == 0) fin_cycle(up, MASK_ALL, pv, pn);
            else tick();
        end
    endtask

    initial begin
        bit we, hit;
        logic [2:0] ls;
        rst_n  = 1'b0;
        in_idle();
        exp_cr = 5'd0;
        exp_clear();
        pin_mask = '0;
        pin_val  = '0;
        chk_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Load miss into an empty line: read_shared refill, response state from RRESP
        cpu_txn(0, 0, 3'd4, 0, 0, 0, 1, 1, 2, 1, 1, 1, MASK_NO_CR,
                (26'd1 << B_DONE) | (26'd1 << B_WFI) | (26'd1 << B_RRE) | (26'd1 << B_RR) | (26'd1 << B_RS),
                "load_refill");
        // Store hit on a UC line completes in LOOKUP
        cpu_txn(1, 1, 3'd0, 0, 0, 0, 1, 0, 0, 1, 1, 1, MASK_NO_CR,
                (26'd1 << B_DONE) | (26'd1 << B_WFC) | (26'd1 << B_MUX) | (26'd1 << B_NS0), "store_hit_uc");
        // Store miss on an SD victim: AW two cycles ahead of W, then make_unique refill and merge
        cpu_txn(1, 0, 3'd3, 0, 2, 1, 1, 1, 1, 1, 1, 1, MASK_NO_CR,
                (26'd1 << B_DONE) | (26'd1 << B_WFC) | (26'd1 << B_MUX) | (26'd1 << B_NS0), "store_miss_merge");
        // Snoop and CPU request collide: snoop served first, CPU load follows
        snoop_txn(5'b01001, 0, 0, 1, 2, 1, 0, 1,
                  (26'd1 << B_CRV) | (26'd1 << B_CDV) | 26'b01001, "snoop_first");
        cpu_txn(0, 1, 3'd2, 0, 0, 0, 1, 0, 0, 1, 1, 0, '0, '0, "");
        // Load miss with a failing read response
        cpu_txn(0, 0, 3'd0, 0, 0, 0, 1, 0, 1, 0, 1, 1, MASK_NO_CR,
                (26'd1 << B_ERR) | (26'd1 << B_RR) | (26'd1 << B_RS), "load_r_err");
        // R without R_LAST, failed write-back response, upgrade of a shared line
        cpu_txn(0, 0, 3'd2, 0, 0, 0, 1, 0, 0, 1, 0, 1, MASK_NO_CR,
                (26'd1 << B_ERR) | (26'd1 << B_RR) | (26'd1 << B_RS), "r_no_last");
        cpu_txn(0, 0, 3'd1, 1, 0, 2, 0, 0, 0, 1, 1, 1, MASK_NO_CR,
                (26'd1 << B_ERR) | (26'd1 << B_BR), "b_err");
        cpu_txn(1, 1, 3'd2, 0, 0, 0, 1, 2, 1, 1, 1, 1, MASK_NO_CR,
                (26'd1 << B_DONE) | (26'd1 << B_WFC) | (26'd1 << B_MUX) | (26'd1 << B_NS0), "upgrade_merge");
        // Snoop on a missed line reports a clean response with no data
        snoop_txn(5'b10111, 1, 0, 0, 0, 0, 0, 1, (26'd1 << B_CRV), "snoop_miss");

        // Reset in the middle of an address phase drops everything at once
        drive_cpu(0); exp_clear(); tick();
        drive_cpu(0); cache_miss = 1'b1; line_state = 3'd4; exp_clear(); tick();
        drive_cpu(0); exp_clear(); exp_v[B_AR] = 1'b1; exp_v[B_RS] = 1'b1; tick();
        in_idle();
        rst_n  = 1'b0;
        exp_cr = 5'd0;
        exp_clear();
        #1;
        pin_en = 1'b1; pin_mask = MASK_ALL; pin_val = '0; pin_name = "mid_reset";
        tick();
        rst_n = 1'b1;
        exp_clear();
        tick();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                snoop_txn(5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 3), $urandom_range(0, 3), rbit(), rbit(), 0, '0, "");
            end
            we  = rbit();
            hit = rbit();
            ls  = hit ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 4));
            if (cpu_req) we = cpu_we;
            cpu_txn(we, hit, ls, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) != 0), 0, '0, '0, "");
            if ($urandom_range(0, 3) == 0) begin
                in_idle();
                exp_clear();
                tick();
            end
        end
        in_idle();
        exp_clear();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
